// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MIPS CPU run/halt supervisor.
//   run_state_t         : supervisor states (reset sequencing, running,
//                         ended by halt/stall, ended by timeout)
//   INSTR_W             : instruction word width
//   HALT_WORD_DEFAULT   : encoding of "beq $0,$0,-1", the spin-in-place halt
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'h1000FFFF;

  typedef enum logic [1:0] {
    S_RST_SEQ = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } run_state_t;

endpackage

// File: rtl/pc_stall_detector.sv
// ---------------------------------------------------------------------------
// pc_stall_detector
// Watches the CPU fetch PC and flags a program that has stopped advancing.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   enable   in   high while the CPU is running; low clears the history
//   pc       in   current fetch PC
//   stalled  out  high in the cycle where the PC has been unchanged for
//                 STALL_CYCLES consecutive cycles (STALL_CYCLES-1 earlier
//                 matches plus a match this cycle)
// ---------------------------------------------------------------------------
module pc_stall_detector #(
  parameter int PC_W         = 32,
  parameter int STALL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [PC_W-1:0] pc,
  output logic            stalled
);

  localparam int SC_W = $clog2(STALL_CYCLES);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STALL_CYCLES - 1);

  logic [PC_W-1:0] prev_pc;
  logic            prev_valid;
  logic [SC_W-1:0] stall_cnt;
  logic            same_pc;

  // A match needs a previous sample taken while enabled, so the very first
  // enabled cycle can never look like a repeat of stale history.
  assign same_pc = enable && prev_valid && (pc == prev_pc);
  assign stalled = same_pc && (stall_cnt == SC_LAST);

  // Keep one cycle of PC history and count how many consecutive cycles it
  // repeated. Any change of PC, or dropping enable, restarts the count. The
  // counter saturates because the supervisor leaves RUN as soon as it fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      prev_pc    <= pc;
      prev_valid <= enable;
      if (!same_pc) begin
        stall_cnt <= '0;
      end else if (stall_cnt != SC_LAST) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// ---------------------------------------------------------------------------
// cpu_run_controller
// Run/halt supervisor for the MIPS CPU: holds the CPU in reset for a fixed
// number of cycles, lets it run while counting cycles, and ends the run on a
// halt instruction, a stalled PC, or a timeout.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   single-cycle pulse, restarts a run (ignored while the
//                   reset sequence is in progress)
//   pc         in   current CPU fetch PC
//   instr      in   instruction word at pc
//   cpu_rst    out  active-high reset to the CPU
//   running    out  high while the CPU is running
//   done       out  sticky, run ended by halt instruction or stalled PC
//   timed_out  out  sticky, run ended by timeout
//   cycles     out  run cycles elapsed in the current or last run
//   halt_pc    out  PC captured when the last run ended
// ---------------------------------------------------------------------------
module cpu_run_controller
  import cpu_pkg::*;
#(
  parameter int                 PC_W         = 32,
  parameter int                 CNT_W        = 32,
  parameter int                 RST_CYCLES   = 2,
  parameter int                 TIMEOUT      = 500,
  parameter int                 STALL_CYCLES = 4,
  parameter logic [INSTR_W-1:0] HALT_WORD    = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic               cpu_rst,
  output logic               running,
  output logic               done,
  output logic               timed_out,
  output logic [CNT_W-1:0]   cycles,
  output logic [PC_W-1:0]    halt_pc
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT - 1);

  run_state_t       state;
  logic [RST_W-1:0] rst_cnt;
  logic             in_run;
  logic             halt_hit;
  logic             stalled;

  // Instruction and PC checks only mean anything while the CPU is running;
  // qualifying by state keeps garbage on instr during reset harmless.
  assign in_run   = (state == S_RUN);
  assign halt_hit = in_run && (instr == HALT_WORD);

  pc_stall_detector #(
    .PC_W        (PC_W),
    .STALL_CYCLES(STALL_CYCLES)
  ) u_stall (
    .clk    (clk),
    .rst    (rst),
    .enable (in_run),
    .pc     (pc),
    .stalled(stalled)
  );

  // Supervisor FSM with all outputs registered. A restart request wins over
  // everything else once the reset sequence is over; within RUN a halt or
  // stall wins over a timeout landing in the same cycle. When a run ends the
  // cycle count is left at the value of the final cycle rather than bumped,
  // so it reads the same as it did when the end condition was seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RST_SEQ;
      rst_cnt   <= '0;
      cpu_rst   <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      cycles    <= '0;
      halt_pc   <= '0;
    end else if (start && (state != S_RST_SEQ)) begin
      state     <= S_RST_SEQ;
      rst_cnt   <= '0;
      cpu_rst   <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      cycles    <= '0;
    end else begin
      case (state)
        S_RST_SEQ: begin
          if (rst_cnt == RST_LAST) begin
            state   <= S_RUN;
            rst_cnt <= '0;
            cpu_rst <= 1'b0;
            running <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (halt_hit || stalled) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
            halt_pc <= pc;
          end else if (cycles == CYC_LAST) begin
            state     <= S_TIMEOUT;
            running   <= 1'b0;
            timed_out <= 1'b1;
            halt_pc   <= pc;
          end else begin
            cycles <= cycles + 1'b1;
          end
        end
        S_DONE, S_TIMEOUT: begin
          state <= state;
        end
        default: begin
          state <= S_RST_SEQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_controller
// Self-checking bench for the CPU run/halt supervisor with RST_CYCLES=2,
// TIMEOUT=16, STALL_CYCLES=4. A behavioural model tracks the reset cycles
// left, the run cycle count, the streak of repeated PCs and the sticky
// flags, and every scenario compares the DUT outputs against it.
// ---------------------------------------------------------------------------
module tb_cpu_run_controller;
  import cpu_pkg::*;

  localparam int PC_W         = 32;
  localparam int CNT_W        = 32;
  localparam int RST_CYCLES   = 2;
  localparam int TIMEOUT      = 16;
  localparam int STALL_CYCLES = 4;
  localparam logic [31:0] HALT = 32'h1000FFFF;

  logic              clk   = 1'b0;
  logic              rst   = 1'b0;
  logic              start = 1'b0;
  logic [PC_W-1:0]   pc    = '0;
  logic [31:0]       instr = '0;
  logic              cpu_rst;
  logic              running;
  logic              done;
  logic              timed_out;
  logic [CNT_W-1:0]  cycles;
  logic [PC_W-1:0]   halt_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_rst_left;
  bit          m_running;
  bit          m_done;
  bit          m_to;
  int unsigned m_cycles;
  logic [31:0] m_halt_pc;
  logic [31:0] m_prev_pc;
  bit          m_have_prev;
  int          m_streak;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .PC_W        (PC_W),
    .CNT_W       (CNT_W),
    .RST_CYCLES  (RST_CYCLES),
    .TIMEOUT     (TIMEOUT),
    .STALL_CYCLES(STALL_CYCLES),
    .HALT_WORD   (HALT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pc       (pc),
    .instr    (instr),
    .cpu_rst  (cpu_rst),
    .running  (running),
    .done     (done),
    .timed_out(timed_out),
    .cycles   (cycles),
    .halt_pc  (halt_pc)
  );

  // Model state right after an asynchronous reset is released.
  function automatic void model_reset();
    m_rst_left  = RST_CYCLES;
    m_running   = 1'b0;
    m_done      = 1'b0;
    m_to        = 1'b0;
    m_cycles    = 0;
    m_halt_pc   = '0;
    m_prev_pc   = '0;
    m_have_prev = 1'b0;
    m_streak    = 0;
  endfunction

  // One rising clock edge of the supervisor, from its rules: the CPU reset
  // lasts RST_CYCLES edges, restarts are ignored during it, a halt word or
  // the STALL_CYCLES-th consecutive repeated PC ends the run, otherwise the
  // last permitted cycle ends it by timeout.
  function automatic void model_step(bit s, logic [31:0] p, logic [31:0] i);
    bit eq;
    int streak;
    if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) begin
        m_running   = 1'b1;
        m_cycles    = 0;
        m_have_prev = 1'b0;
        m_streak    = 0;
      end
    end else if (s) begin
      m_rst_left = RST_CYCLES;
      m_running  = 1'b0;
      m_done     = 1'b0;
      m_to       = 1'b0;
      m_cycles   = 0;
    end else if (m_running) begin
      eq     = m_have_prev && (p == m_prev_pc);
      streak = eq ? m_streak + 1 : 0;
      if ((i === HALT) || (streak >= STALL_CYCLES)) begin
        m_running = 1'b0;
        m_done    = 1'b1;
        m_halt_pc = p;
      end else if (m_cycles == TIMEOUT - 1) begin
        m_running = 1'b0;
        m_to      = 1'b1;
        m_halt_pc = p;
      end else begin
        m_cycles++;
      end
      m_prev_pc   = p;
      m_have_prev = 1'b1;
      m_streak    = streak;
    end
  endfunction

  function automatic logic [3:0] exp_flags();
    return {(m_rst_left > 0), m_running, m_done, m_to};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = ~w;
    return w;
  endfunction

  // PC an incrementing program would fetch: 4 bytes per run cycle.
  function automatic logic [31:0] seq_pc();
    return (m_rst_left > 0) ? 32'($urandom) : 32'(m_cycles * 4);
  endfunction

  // Drive inputs for one edge, advance the model, then settle past the edge.
  task automatic tick(input bit s, input logic [31:0] p, input logic [31:0] i);
    start = s;
    pc    = p;
    instr = i;
    @(posedge clk);
    if (rst) model_step(s, p, i);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 3;
    if ({cpu_rst, running, done, timed_out} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL reset_values flags: got %b, required %b", {cpu_rst, running, done, timed_out}, 4'b1000);
    end
    if (cycles !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_values cycles: got %0d, required 0", cycles);
    end
    if (halt_pc !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_values halt_pc: got %h, required 0", halt_pc);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    // two reset cycles then run cycles 0..4, with X on instr while in reset
    for (int k = 0; k < 7; k++) begin
      tick(1'b0, seq_pc(), (m_rst_left > 0) ? 32'hxxxx_xxxx : rand_instr());
      n_checks += 2;
      if ({cpu_rst, running, done, timed_out} !== exp_flags()) begin
        n_fail++;
        $display("[TB] FAIL reset_seq flags step %0d: got %b, required %b", k, {cpu_rst, running, done, timed_out}, exp_flags());
      end
      if (cycles !== m_cycles) begin
        n_fail++;
        $display("[TB] FAIL reset_seq cycles step %0d: got %0d, required %0d", k, cycles, m_cycles);
      end
    end
  endtask

  task automatic test_halt();
    for (int k = 0; k < 20 && !(m_running && m_cycles == 5); k++) tick(1'b0, seq_pc(), rand_instr());
    tick(1'b0, 32'h14, HALT);
    n_checks += 3;
    if ({running, done, timed_out} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL halt flags {running,done,timed_out}: got %b, required 010", {running, done, timed_out});
    end
    if (halt_pc !== 32'h14) begin
      n_fail++;
      $display("[TB] FAIL halt halt_pc: got %h, required 00000014", halt_pc);
    end
    if (cycles !== 5) begin
      n_fail++;
      $display("[TB] FAIL halt cycles: got %0d, required 5", cycles);
    end
    // frozen afterwards whatever the CPU fetches
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, $urandom, (k == 1) ? HALT : rand_instr());
      n_checks += 3;
      if ({cpu_rst, running, done, timed_out} !== exp_flags()) begin
        n_fail++;
        $display("[TB] FAIL halt_frozen flags: got %b, required %b", {cpu_rst, running, done, timed_out}, exp_flags());
      end
      if (cycles !== m_cycles) begin
        n_fail++;
        $display("[TB] FAIL halt_frozen cycles: got %0d, required %0d", cycles, m_cycles);
      end
      if (halt_pc !== m_halt_pc) begin
        n_fail++;
        $display("[TB] FAIL halt_frozen halt_pc: got %h, required %h", halt_pc, m_halt_pc);
      end
    end
  endtask

  task automatic test_stall();
    tick(1'b1, $urandom, rand_instr());
    for (int k = 0; k < 60 && !(m_done || m_to); k++) begin
      tick(1'b0, (m_running && m_cycles >= 3) ? 32'h20 : seq_pc(), rand_instr());
      n_checks += 2;
      if ({cpu_rst, running, done, timed_out} !== exp_flags()) begin
        n_fail++;
        $display("[TB] FAIL stall flags: got %b, required %b", {cpu_rst, running, done, timed_out}, exp_flags());
      end
      if (cycles !== m_cycles) begin
        n_fail++;
        $display("[TB] FAIL stall cycles: got %0d, required %0d", cycles, m_cycles);
      end
    end
    n_checks += 3;
    if ({done, timed_out} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL stall end {done,timed_out}: got %b, required 10", {done, timed_out});
    end
    if (halt_pc !== 32'h20) begin
      n_fail++;
      $display("[TB] FAIL stall halt_pc: got %h, required 00000020", halt_pc);
    end
    if (cycles !== 7) begin
      n_fail++;
      $display("[TB] FAIL stall cycles at end: got %0d, required 7", cycles);
    end
  endtask

  task automatic test_timeout();
    tick(1'b1, $urandom, rand_instr());
    for (int k = 0; k < 60 && !(m_done || m_to); k++) begin
      tick(1'b0, seq_pc(), rand_instr());
      n_checks += 1;
      if ({cpu_rst, running, done, timed_out} !== exp_flags() || cycles !== m_cycles) begin
        n_fail++;
        $display("[TB] FAIL timeout_run flags/cycles: got %b/%0d, required %b/%0d", {cpu_rst, running, done, timed_out}, cycles, exp_flags(), m_cycles);
      end
    end
    n_checks += 3;
    if ({done, timed_out} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL timeout end {done,timed_out}: got %b, required 01", {done, timed_out});
    end
    if (cycles !== TIMEOUT - 1) begin
      n_fail++;
      $display("[TB] FAIL timeout cycles: got %0d, required %0d", cycles, TIMEOUT - 1);
    end
    if (halt_pc !== 32'h3c) begin
      n_fail++;
      $display("[TB] FAIL timeout halt_pc: got %h, required 0000003c", halt_pc);
    end
  endtask

  task automatic test_coincidence_restart();
    tick(1'b1, $urandom, rand_instr());
    for (int k = 0; k < 60 && !(m_done || m_to); k++) begin
      tick(1'b0, seq_pc(), (m_running && m_cycles == TIMEOUT - 1) ? HALT : rand_instr());
    end
    n_checks += 3;
    if ({done, timed_out} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL coincide {done,timed_out}: got %b, required 10", {done, timed_out});
    end
    if (cycles !== TIMEOUT - 1) begin
      n_fail++;
      $display("[TB] FAIL coincide cycles: got %0d, required %0d", cycles, TIMEOUT - 1);
    end
    if (halt_pc !== 32'h3c) begin
      n_fail++;
      $display("[TB] FAIL coincide halt_pc: got %h, required 0000003c", halt_pc);
    end
    tick(1'b1, $urandom, rand_instr());
    n_checks += 3;
    if ({cpu_rst, running, done, timed_out} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL restart flags: got %b, required 1000", {cpu_rst, running, done, timed_out});
    end
    if (cycles !== 0) begin
      n_fail++;
      $display("[TB] FAIL restart cycles: got %0d, required 0", cycles);
    end
    if (halt_pc !== 32'h3c) begin
      n_fail++;
      $display("[TB] FAIL restart halt_pc held: got %h, required 0000003c", halt_pc);
    end
    // start again while still in the reset sequence: must be ignored
    for (int k = 0; k < 3; k++) begin
      tick(k == 0, seq_pc(), rand_instr());
      n_checks += 2;
      if ({cpu_rst, running, done, timed_out} !== exp_flags()) begin
        n_fail++;
        $display("[TB] FAIL restart_seq flags step %0d: got %b, required %b", k, {cpu_rst, running, done, timed_out}, exp_flags());
      end
      if (halt_pc !== m_halt_pc) begin
        n_fail++;
        $display("[TB] FAIL restart_seq halt_pc: got %h, required %h", halt_pc, m_halt_pc);
      end
    end
  endtask

  task automatic test_midrun_reset();
    tick(1'b1, $urandom, rand_instr());
    for (int k = 0; k < 40 && !(m_running && m_cycles == 7); k++) tick(1'b0, seq_pc(), rand_instr());
    #2;
    rst = 1'b0;
    #1;
    n_checks += 3;
    if ({cpu_rst, running, done, timed_out} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL midrun_reset flags: got %b, required 1000", {cpu_rst, running, done, timed_out});
    end
    if (cycles !== 0) begin
      n_fail++;
      $display("[TB] FAIL midrun_reset cycles: got %0d, required 0", cycles);
    end
    if (halt_pc !== 0) begin
      n_fail++;
      $display("[TB] FAIL midrun_reset halt_pc: got %h, required 0", halt_pc);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [31:0] last_pc;
    logic [31:0] p;
    int hold_left;
    last_pc   = '0;
    hold_left = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold_left > 0) begin
        p = last_pc;
        hold_left--;
      end else begin
        p = last_pc + 32'(4 * $urandom_range(1, 3));
        if ($urandom_range(0, 5) == 0) hold_left = $urandom_range(1, 6);
      end
      last_pc = p;
      tick($urandom_range(0, 24) == 0, p,
           (m_rst_left > 0 && $urandom_range(0, 1) == 0) ? 32'hxxxx_xxxx :
           ($urandom_range(0, 29) == 0) ? HALT : rand_instr());
      n_checks += 4;
      if ({cpu_rst, running, done, timed_out} !== exp_flags()) begin
        n_fail++;
        $display("[TB] FAIL random flags step %0d: got %b, required %b", k, {cpu_rst, running, done, timed_out}, exp_flags());
      end
      if (cycles !== m_cycles) begin
        n_fail++;
        $display("[TB] FAIL random cycles step %0d: got %0d, required %0d", k, cycles, m_cycles);
      end
      if (halt_pc !== m_halt_pc) begin
        n_fail++;
        $display("[TB] FAIL random halt_pc step %0d: got %h, required %h", k, halt_pc, m_halt_pc);
      end
      if (done && timed_out) begin
        n_fail++;
        $display("[TB] FAIL random exclusive flags step %0d: got done=1 timed_out=1, required not both", k);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_halt();
    test_stall();
    test_timeout();
    test_coincidence_restart();
    test_midrun_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Synthesizable run/halt supervisor for the MIPS CPU. It replaces hand-timed reset pulses and fixed `$finish` delays in benches and on-board bring-up.
- Sequences the CPU reset for a programmable length, then counts cycles while the CPU runs.
- Detects program completion (halt instruction or stalled PC) or a timeout, and reports status and the final PC.
- Sits beside the CPU top: drives the CPU's reset and observes the fetch PC and instruction.

Parameters:
- PC_W, 32, width of the observed program counter
- CNT_W, 32, width of the cycle counter
- RST_CYCLES, 2, cycles `cpu_rst` is held high per run (legal range ≥1)
- TIMEOUT, 500, maximum RUN cycles before declaring a timeout (legal range ≥2, < 2^CNT_W)
- STALL_CYCLES, 4, consecutive cycles with an unchanged PC that count as a halt (legal range ≥2)
- HALT_WORD, 32'h1000FFFF, instruction encoding treated as halt (`beq $0,$0,-1`)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse: (re)start a run
- pc  in  PC_W  current fetch PC from the CPU
- instr  in  32  instruction word at `pc` from instruction memory
- cpu_rst  out  1  active-high reset to the CPU
- running  out  1  high while in RUN
- done  out  1  sticky: run ended by halt or stall
- timed_out  out  1  sticky: run ended by timeout
- cycles  out  CNT_W  RUN cycles elapsed in the current or last run
- halt_pc  out  PC_W  PC captured at the end of the run

Behaviour:
- Async reset (`rst`=0):
  - state=RST_SEQ, `cpu_rst`=1, `running`=0, `done`=0, `timed_out`=0, `cycles`=0, `halt_pc`=0.
  - Internal reset counter, stall counter and previous-PC register cleared.
- States: RST_SEQ, RUN, DONE, TIMEOUT. All outputs are registered.
- RST_SEQ:
  - `cpu_rst`=1; reset counter increments each cycle.
  - After RST_CYCLES cycles in RST_SEQ, go to RUN. `cpu_rst` falls on the same edge.
  - `start` is ignored in this state.
- RUN:
  - `running`=1, `cpu_rst`=0; `cycles` increments by 1 each cycle.
  - The first RUN cycle after the transition shows `cycles`=0.
- Halt detect: in RUN, `instr`==HALT_WORD → next state DONE, `done`=1, `halt_pc`<=`pc`.
- Stall detect:
  - Compare `pc` with `pc` registered from the previous cycle. Equal → stall counter +1; different → stall counter cleared.
  - The first RUN cycle never counts as equal.
  - Stall counter reaching STALL_CYCLES-1 while equal → DONE, `done`=1, `halt_pc`<=`pc`.
- Timeout:
  - In RUN, `cycles`==TIMEOUT-1 with no halt or stall this cycle → TIMEOUT, `timed_out`=1, `halt_pc`<=`pc`.
  - `cycles` never exceeds TIMEOUT.
- Priority when events coincide in the same cycle: `start` > halt/stall > timeout.
- DONE / TIMEOUT:
  - `running`=0, `cpu_rst`=0; the CPU is left free-running.
  - `cycles` and `halt_pc` are frozen; flags are sticky.
- `start` in RUN, DONE or TIMEOUT:
  - Next state RST_SEQ.
  - Clears `done`, `timed_out`, `cycles` and the stall/reset counters.
  - Sets `cpu_rst`=1 and `running`=0.
  - `halt_pc` is held until the next end of run.
- `done` and `timed_out` are mutually exclusive at all times.
- `rst` asserted mid-run: immediate return to reset values, including `cpu_rst`=1. No partial state survives.
- X on `instr` during RST_SEQ has no effect: comparisons are qualified by state==RUN.

Decomposition:
- Shared package `cpu_pkg`:
  - State enum localparams (RST_SEQ, RUN, DONE, TIMEOUT).
  - HALT_WORD default constant.
  - Instruction width localparam (32).
- One natural sub-module, `pc_stall_detector`:
  - Holds the previous-PC register and the stall counter, parametrised by PC_W and STALL_CYCLES.
  - Inputs: `enable`, `pc`. Output: `stalled` pulse.
- The FSM, reset counter and cycle counter remain in the top.

Test Plan (RST_CYCLES=2, TIMEOUT=16, STALL_CYCLES=4):
- Reset and sequence:
  - Stimulus: `rst`=0 for 3 cycles, then release; `pc` increments by 4 each cycle.
  - Required: `cpu_rst`=1 for exactly 2 cycles after release, then 0. `running` rises on the same edge. `cycles` counts 0,1,2,…
- Halt word:
  - Stimulus: in RUN at `cycles`=5, `instr`=32'h1000FFFF with `pc`=32'h14.
  - Required: next edge `done`=1, `halt_pc`=32'h14, `running`=0, `cycles` frozen at 5.
- Stall:
  - Stimulus: `pc` held at 32'h20 from `cycles`=3 onward; `instr` not the halt word.
  - Required: `done`=1 after 4 equal-PC cycles, `halt_pc`=32'h20, `timed_out`=0.
- Timeout:
  - Stimulus: `pc` keeps incrementing; no halt.
  - Required: at `cycles`=15, next edge `timed_out`=1, `done`=0, `cycles` holds 15.
- Coincidence and restart:
  - Stimulus: halt word presented exactly at `cycles`=15.
  - Required: `done`=1, `timed_out`=0.
  - Follow-up: `start` pulse → flags clear, `cycles`=0, `cpu_rst` high 2 cycles, `halt_pc` retains its old value until the next end of run.
- Mid-run reset:
  - Stimulus: `rst`=0 at `cycles`=7.
  - Required: same cycle, asynchronously: `cpu_rst`=1, `running`=0, `cycles`=0, all flags 0.
